// File: rtl/gcd_operand_feeder.sv
// Buffers operand pairs in a small FIFO and issues them one at a time to the GCD core.
// It waits for core_done or a timeout, then holds the result record until the consumer accepts it.
module gcd_operand_feeder #(
  parameter int WIDTH   = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] fifo_a_q [DEPTH];
  logic [WIDTH-1:0] fifo_b_q [DEPTH];

  logic             start_q, start_d;
  logic [WIDTH-1:0] core_a_q, core_a_d, core_b_q, core_b_d;
  logic             out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_result_q, out_result_d;

  logic push, pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_a;
      fifo_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    start_d      = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_result_d = out_result_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          core_a_d = fifo_a_q[rd_ptr_q];
          core_b_d = fifo_b_q[rd_ptr_q];
          start_d  = 1'b1;
          timer_d  = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done strobe on the final timer cycle still counts as success.
        if (core_done) begin
          out_result_d = core_result;
          out_a_d      = core_a_q;
          out_b_d      = core_b_q;
          out_err_d    = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          out_result_d = '0;
          out_a_d      = core_a_q;
          out_b_d      = core_b_q;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      start_q      <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      start_q      <= start_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_result_q <= out_result_d;
    end
  end

  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign core_start = start_q;
  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a behavioural GCD core whose done delay is programmable.
module tb_gcd_operand_feeder;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] core_a, core_b;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [W-1:0] core_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a, out_b, out_result;
  logic         out_err;

  gcd_operand_feeder #(.WIDTH(W), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_start(core_start),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_result(out_result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: done arrives `delay` cycles after the start pulse; negative means never.
  int           delay = 4;
  int           cnt = 0;
  bit           pending = 1'b0;
  logic [W-1:0] ra, rb;
  int           done_n = 0;
  always @(negedge clk) begin
    core_done   = 1'b0;
    core_result = '0;
    if (core_start) begin
      pending = (delay >= 0);
      cnt     = delay;
      ra      = core_a;
      rb      = core_b;
    end else if (pending) begin
      cnt = cnt - 1;
    end
    if (pending && cnt == 0) begin
      core_done   = 1'b1;
      core_result = gcd(ra, rb);
      pending     = 1'b0;
      done_n++;
    end
  end

  int           start_n = 0;
  int           start_cyc = 0;
  int           st_cyc[$];
  logic [W-1:0] st_a[$], st_b[$];
  int           lat_q[$];
  logic         prev_v = 1'b0;
  logic [W-1:0] rx_a[$], rx_b[$], rx_r[$];
  logic         rx_e[$];
  always @(negedge clk) begin
    #1;
    if (core_start) begin
      start_n++;
      start_cyc = cyc;
      st_cyc.push_back(cyc);
      st_a.push_back(core_a);
      st_b.push_back(core_b);
    end
    if (out_valid && !prev_v) lat_q.push_back(cyc - start_cyc);
    prev_v = out_valid;
    if (out_valid && out_ready) begin
      rx_a.push_back(out_a);
      rx_b.push_back(out_b);
      rx_r.push_back(out_result);
      rx_e.push_back(out_err);
    end
  end

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int pcyc, output int waited);
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) chk("push_stuck", 0, 1);
    @(negedge clk);
    pcyc     = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_a.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (rx_a.size() < n) chk("wait_rx", rx_a.size(), n);
  endtask

  task automatic chk_rec(input string tag, input int idx, input int a, input int b, input int r, input int e);
    if (idx >= rx_a.size()) begin
      chk({tag, "_missing"}, rx_a.size(), idx + 1);
    end else begin
      chk({tag, "_a"}, rx_a[idx], a);
      chk({tag, "_b"}, rx_b[idx], b);
      chk({tag, "_res"}, rx_r[idx], r);
      chk({tag, "_err"}, rx_e[idx], e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int pc, w, s0, r0, l0, dn, rc;
  logic [W-1:0] ha, hb, hr;
  bit stable;
  logic [W-1:0] b_a[5] = '{12, 7, 0, 20, 31};
  logic [W-1:0] b_b[5] = '{18, 5, 9, 8, 31};
  int           b_r[5] = '{6, 1, 9, 4, 31};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_out_result", out_result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single job, done four cycles after start.
    delay = 4; out_ready = 1'b1;
    s0 = start_n; r0 = rx_a.size(); l0 = lat_q.size();
    push(27, 15, pc, w);
    wait_rx(r0 + 1);
    repeat (3) @(negedge clk);
    chk("t1_starts", start_n - s0, 1);
    chk("t1_core_a", st_a[s0], 27);
    chk("t1_core_b", st_b[s0], 15);
    chk("t1_push2start", st_cyc[s0] - pc, 1);
    chk("t1_start2valid", lat_q[l0], 5);
    chk_rec("t1", r0, 27, 15, 3, 0);

    // Burst while a slow job is in flight: FIFO fills after four pushes.
    delay = 10;
    s0 = start_n; r0 = rx_a.size();
    push(3, 9, pc, w);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) push(b_a[i], b_b[i], pc, w);
    chk("t2_full_rdy", in_ready, 0);
    push(b_a[4], b_b[4], pc, w);
    chk("t2_fifth_stalled", (w > 0), 1);
    wait_rx(r0 + 6);
    chk_rec("t2_j0", r0, 3, 9, 3, 0);
    for (int i = 0; i < 5; i++) chk_rec($sformatf("t2_j%0d", i + 1), r0 + 1 + i, b_a[i], b_b[i], b_r[i], 0);
    repeat (5) @(negedge clk);
    chk("t2_starts", start_n - s0, 6);
    chk("t2_records", rx_a.size() - r0, 6);

    // Timeout, then the queued job completes normally.
    delay = -1;
    s0 = start_n; r0 = rx_a.size(); l0 = lat_q.size();
    push(9, 6, pc, w);
    push(10, 4, pc, w);
    w = 0;
    while (start_n == s0 && w < 20) begin @(negedge clk); w++; end
    delay = 3;
    wait_rx(r0 + 2);
    chk_rec("t3_to", r0, 9, 6, 0, 1);
    chk("t3_timeout_lat", lat_q[l0], 64);
    chk_rec("t3_next", r0 + 1, 10, 4, 2, 0);
    chk("t3_next_lat", lat_q[l0 + 1], 4);

    // Consumer stalls for 20 cycles.
    delay = 2; out_ready = 1'b0;
    r0 = rx_a.size();
    push(14, 21, pc, w);
    push(25, 10, pc, w);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    ha = out_a; hb = out_b; hr = out_result; s0 = start_n; stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_a != ha || out_b != hb || out_result != hr || out_err) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    chk("t4_held_res", hr, 7);
    chk("t4_no_start", start_n - s0, 0);
    out_ready = 1'b1;
    rc = cyc;
    wait_rx(r0 + 2);
    chk("t4_accept2start", st_cyc[s0] - rc, 2);
    chk_rec("t4_j0", r0, 14, 21, 7, 0);
    chk_rec("t4_j1", r0 + 1, 25, 10, 5, 0);

    // Done on the last timer cycle wins; one cycle later it is too late.
    delay = 63;
    r0 = rx_a.size(); l0 = lat_q.size();
    push(18, 12, pc, w);
    wait_rx(r0 + 1);
    chk_rec("t6_edge", r0, 18, 12, 6, 0);
    chk("t6_edge_lat", lat_q[l0], 64);
    delay = 64;
    dn = done_n;
    push(21, 14, pc, w);
    wait_rx(r0 + 2);
    repeat (10) @(negedge clk);
    chk_rec("t6_late", r0 + 1, 21, 14, 0, 1);
    chk("t6_late_lat", lat_q[l0 + 1], 64);
    chk("t6_late_done_fired", done_n - dn, 1);
    chk("t6_no_extra", rx_a.size() - r0, 2);

    // Reset mid-job with three queued entries; a late done must be ignored.
    delay = 20;
    r0 = rx_a.size(); l0 = lat_q.size();
    push(1, 2, pc, w);
    push(3, 4, pc, w);
    push(5, 6, pc, w);
    push(7, 8, pc, w);
    repeat (3) @(negedge clk);
    dn = done_n; s0 = start_n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_core_a", core_a, 0);
    repeat (30) @(negedge clk);
    chk("t5_late_done_fired", done_n - dn, 1);
    chk("t5_no_start", start_n - s0, 0);
    chk("t5_no_valid", lat_q.size() - l0, 0);
    chk("t5_no_record", rx_a.size() - r0, 0);
    delay = 1;
    push(6, 4, pc, w);
    wait_rx(r0 + 1);
    chk_rec("t5_recover", r0, 6, 4, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
